rgb_to_greyscale_stage: RTL
===========================

# rgb_to_greyscale_stage

Streaming colour-conversion stage in the `wr_clk` domain: pops packed 24-bit RGB pixels from an upstream first-word-fall-through FIFO and writes 8-bit luma into the write port of the greyscale-to-subtractor FIFO. A three-stage pipeline computes the fixed-point BT.601 approximation. A frame controller processes exactly `IMG_WIDTH*IMG_HEIGHT` pixels per `start` and reports completion.

## Interface
- `IMG_WIDTH`, 720, pixels per line.
- `IMG_HEIGHT`, 540, lines per frame.
- `DATA_WIDTH`, 8, output pixel width; only 8 is supported.
- `wr_clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high; clock `wr_clk`.
- `start`  in  1  frame start request.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse after the frame's last output write.
- `in_dout`  in  24  head pixel: R[23:16], G[15:8], B[7:0]; valid while `in_empty`=0.
- `in_empty`  in  1  upstream FIFO empty.
- `in_rd_en`  out  1  pop upstream head this cycle.
- `out_din`  out  DATA_WIDTH  greyscale pixel.
- `out_wr_en`  out  1  write `out_din` downstream this cycle.
- `out_full`  in  1  downstream FIFO full.

## Operation
- Luma: Y = (77·R + 150·G + 29·B + 128) >> 8.
  - Weights sum to 256. The 16-bit unsigned sum has a maximum of 65408, so there is no overflow and no saturation.
  - Y ranges from 0 to 255.
- Pipeline:
  - S1 registers RGB.
  - S2 registers the weighted sum plus 128.
  - S3 registers Y.
  - Each stage has its own valid bit.
- Stall: `advance` = !(v3 && `out_full`). All stage registers and valid bits hold when `advance`=0.
  - On `advance`=1, a stage with no incoming data loads valid=0, so bubbles propagate.
- Write control: `out_wr_en` = v3 && !`out_full`. This is combinational and asserted only while `out_full`=0.
- Read control: `in_rd_en` = (state==RUN) && !`in_empty` && `advance`.
- Counters, each `$clog2(IMG_WIDTH*IMG_HEIGHT+1)` bits wide, cleared on leaving IDLE:
  - `in_cnt` increments on `in_rd_en`.
  - `out_cnt` increments on `out_wr_en`.
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on `in_rd_en` when `in_cnt` = total−1.
  - DRAIN → DONE on `out_wr_en` when `out_cnt` = total−1.
  - DONE → IDLE unconditionally.
- Outputs by state:
  - `done` = (state==DONE).
  - `busy` = RUN or DRAIN.
- `start` is ignored outside IDLE.
- An upstream empty mid-frame inserts bubbles only. No pixel is lost or duplicated.
- Reset values: state IDLE, all valid bits 0, counters 0, `out_din` 0. Therefore `in_rd_en`=0, `out_wr_en`=0, `busy`=0, `done`=0.
- Reset mid-frame aborts immediately. In-flight pixels are discarded. The upstream and downstream FIFOs share `reset`.

## Timing
- Latency: a pop in cycle n yields `out_wr_en` in cycle n+3 if `out_full`=0.
- Throughput: one pixel per cycle when the upstream is non-empty and the downstream is not full.
- `out_full` rising with v3=1 freezes the whole pipeline in the same cycle. There are no pops and no writes that cycle. Writing resumes in the first cycle `out_full`=0.
- `done` rises in the cycle after the final `out_wr_en`. `busy` falls in the same cycle.
- After `start` is sampled in IDLE, the first `in_rd_en` can occur in the next cycle.

## Structure
- Package `greyscale_pkg` contains:
  - `rgb_t`, a packed struct {r, g, b} of 8 bits each.
  - The weight constants W_R=77, W_G=150, W_B=29 and ROUND=128.
  - The state enum `grey_state_t` {IDLE, RUN, DRAIN, DONE}.
- Sub-module `greyscale_pixel_pipe` holds the S1–S3 datapath with its valid bits.
  - Inputs: `advance`, `in_valid`, `rgb_t`.
  - Outputs: v3, Y.
- FSM, counters and handshake logic live in the top level.

## Test plan
- IMG 4×2 with pixels (0,0,0), (255,255,255), (255,0,0), (0,255,0), (0,0,255), (100,150,200), (1,1,1), (128,128,128) → `out_din` 0, 255, 77, 149, 29, 141, 1, 128 in order. `done` is a single pulse and `busy` falls with it.
- Upstream always full, downstream never full → `in_rd_en` high for 8 consecutive cycles. The first `out_wr_en` arrives 3 cycles after the first pop.
- `out_full` held high for 5 cycles mid-frame → `out_wr_en`=0 and `in_rd_en`=0 throughout. The output sequence matches the golden model exactly.
- `in_empty` toggling every other cycle → bubbles appear, and 8 writes occur with correct values and no duplicates.
- `start` pulsed during RUN → ignored, and exactly 8 writes and one `done` occur.
- `reset` asserted after 3 pops → all outputs are 0 immediately. A new `start` processes a full fresh frame of 8 pixels.

Source files
------------

// File: rtl/rgb_to_greyscale_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : greyscale_pkg
// Brief   : Shared types and BT.601 fixed-point weights for the greyscale
//           conversion stage.
// Revision: 1.0 - initial release
// ============================================================================
package greyscale_pkg;

  // One packed RGB pixel as it sits at the head of the upstream FIFO
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Luma weights sum to 256, so the result is a plain >>8 of the rounded sum
  localparam logic [15:0] W_R   = 16'd77;
  localparam logic [15:0] W_G   = 16'd150;
  localparam logic [15:0] W_B   = 16'd29;
  localparam logic [15:0] ROUND = 16'd128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } grey_state_t;

  // Weighted sum plus rounding; peaks at 65408, so 16 bits never overflow
  function automatic logic [15:0] luma_sum(input rgb_t p);
    return (W_R * {8'd0, p.r}) + (W_G * {8'd0, p.g}) + (W_B * {8'd0, p.b}) + ROUND;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_to_greyscale_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : rgb_to_greyscale_stage_if
// Brief   : FIFO-side signals of the greyscale stage: upstream FWFT read port
//           and downstream write port.
// Revision: 1.0 - initial release
// ============================================================================
interface rgb_to_greyscale_stage_if #(
  parameter int DATA_WIDTH = 8
);
  import greyscale_pkg::*;

  rgb_t                  in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_wr_en;
  logic                  out_full;

  // The conversion stage: pops upstream, pushes downstream
  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en
  );

  // The FIFO side: presents pixels and flow-control flags
  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en
  );

endinterface
`default_nettype wire

// File: rtl/greyscale_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : greyscale_pixel_pipe
// Brief   : Three-stage RGB to luma datapath (register RGB, weighted sum, Y)
//           with per-stage valid bits and a global hold.
// Revision: 1.0 - initial release
// ============================================================================
module greyscale_pixel_pipe
  import greyscale_pkg::*;
(
  input  wire logic       wr_clk,
  input  wire logic       reset,
  input  wire logic       advance,
  input  wire logic       in_valid,
  input  wire rgb_t       rgb,
  output logic            v3,
  output logic [7:0]      y
);

  rgb_t        r_s1;
  logic        r_v1;
  logic [15:0] r_s2;
  logic        r_v2;
  logic [7:0]  r_s3;
  logic        r_v3;

  // S1: capture the popped pixel; an empty slot becomes a bubble
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (advance) begin
      r_v1 <= in_valid;
      if (in_valid) r_s1 <= rgb;
    end
  end

  // S2: weighted sum with rounding offset
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
    end else if (advance) begin
      r_v2 <= r_v1;
      if (r_v1) r_s2 <= luma_sum(r_s1);
    end
  end

  // S3: luma is the upper byte of the rounded sum
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_v3 <= 1'b0;
      r_s3 <= '0;
    end else if (advance) begin
      r_v3 <= r_v2;
      if (r_v2) r_s3 <= 8'(r_s2 >> 8);
    end
  end

  assign v3 = r_v3;
  assign y  = r_s3;

endmodule
`default_nettype wire

// File: rtl/rgb_to_greyscale_stage.sv
`default_nettype none
// ============================================================================
// Module  : rgb_to_greyscale_stage
// Brief   : Frame-controlled streaming RGB to greyscale converter between an
//           upstream FWFT FIFO and a downstream FIFO write port.
// Revision: 1.0 - initial release
// ============================================================================
module rgb_to_greyscale_stage #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic                       wr_clk,
  input  wire logic                       reset,
  input  wire logic                       start,
  output logic                            busy,
  output logic                            done,
  rgb_to_greyscale_stage_if.master        fifo
);
  import greyscale_pkg::*;

  localparam int               c_total = IMG_WIDTH * IMG_HEIGHT;
  localparam int               CNT_W   = $clog2(c_total + 1);
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(c_total - 1);

  grey_state_t      r_state;
  grey_state_t      w_state_next;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             w_advance;
  logic             w_rd_en;
  logic             w_wr_en;
  logic             w_v3;
  logic [7:0]       w_y;

  // A valid result blocked by a full downstream FIFO freezes every stage
  assign w_advance = !(w_v3 && fifo.out_full);
  assign w_wr_en   = w_v3 && !fifo.out_full;
  assign w_rd_en   = (r_state == RUN) && !fifo.in_empty && w_advance;

  assign fifo.in_rd_en  = w_rd_en;
  assign fifo.out_wr_en = w_wr_en;
  assign fifo.out_din   = w_y[DATA_WIDTH-1:0];

  assign busy = (r_state == RUN) || (r_state == DRAIN);
  assign done = (r_state == DONE);

  greyscale_pixel_pipe u_pipe (
    .wr_clk   (wr_clk),
    .reset    (reset),
    .advance  (w_advance),
    .in_valid (w_rd_en),
    .rgb      (fifo.in_dout),
    .v3       (w_v3),
    .y        (w_y)
  );

  // Frame state register
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Frame sequencing: pop a full frame, then wait for its last write
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_rd_en && (r_in_cnt == c_last)) w_state_next = DRAIN;
      DRAIN:   if (w_wr_en && (r_out_cnt == c_last)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pop/push counters, restarted as each frame begins
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_rd_en) r_in_cnt  <= r_in_cnt + 1'b1;
      if (w_wr_en) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
